// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: owns the read pointer, the empty flag
// and fill count, and presents memory data through a show-ahead output register.
module fifo_rd_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rfill,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    logic [ADDRSIZE:0]   rbin_q, rbin_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic [ADDRSIZE:0]   rfill_q, rfill_d;
    logic                rempty_q, rempty_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic [ADDRSIZE:0]   wbin;
    logic                rpop;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Handshake: a word transfers on every rclk edge where dout_valid && dout_ready;
    // while dout_valid is high and dout_ready low, dout and dout_valid are held.
    always_comb begin
        rpop         = !rempty_q && (!dout_valid_q || dout_ready);
        rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, rpop};
        rptr_d       = (rbin_d >> 1) ^ rbin_d;
        rempty_d     = (rptr_d == rq2_wptr);
        rfill_d      = wbin - rbin_d;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (rpop) begin
            dout_d       = rdata;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rfill_q      <= '0;
            rempty_q     <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rfill_q      <= rfill_d;
            rempty_q     <= rempty_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign rfill      = rfill_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a combinational memory plus a queue-based reference model
// of the unread words and the output register, a scoreboard, and vector tables.
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rrst_n = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rfill;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;

    logic [7:0] mem [16];
    assign rdata = mem[raddr];

    fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk      (clk),
        .rrst_n    (rrst_n),
        .rq2_wptr  (rq2_wptr),
        .rdata     (rdata),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rfill     (rfill),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: the memory contents not yet popped, the output register, flags.
    int         wcnt;
    int         rd_cnt;
    logic       valid_m;
    logic       empty_m;
    logic [7:0] data_m;
    int         fill_m;
    logic [7:0] mem_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] rcv_q[$];
    int         xfer_cyc[$];

    typedef struct {
        int         wtotal;
        logic       ready;
        logic       e_empty;
        logic       e_valid;
        logic [7:0] e_dout;
        int         e_fill;
        logic [4:0] e_rptr;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        wcnt    = 0;
        rd_cnt  = 0;
        valid_m = 1'b0;
        empty_m = 1'b1;
        data_m  = '0;
        fill_m  = 0;
        mem_q.delete();
        exp_q.delete();
        pend_q.delete();
        rcv_q.delete();
        xfer_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_rfill"}, 32'(rfill), 32'd0);
        chk({tag, "_rptr"}, 32'(rptr), 32'd0);
        chk({tag, "_raddr"}, 32'(raddr), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
    endtask

    task automatic do_reset();
        rrst_n     = 1'b0;
        rq2_wptr   = '0;
        dout_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rrst_n = 1'b1;
    endtask

    // One rclk cycle: write up to n_write pending words, drive inputs, score any
    // transfer, then advance the model at the edge and compare.
    task automatic step(input int n_write, input logic ready);
        logic [4:0] prev_rptr;
        logic [7:0] prev_dout;
        logic       prev_hold;
        logic       pop_m;
        logic [7:0] v;
        @(negedge clk);
        for (int i = 0; i < n_write; i++) begin
            if (pend_q.size() > 0 && mem_q.size() < 16) begin
                v = pend_q.pop_front();
                mem[wcnt % 16] = v;
                mem_q.push_back(v);
                exp_q.push_back(v);
                wcnt++;
            end
        end
        rq2_wptr   = gray(wcnt);
        dout_ready = ready;
        #1;
        if (dout_valid && dout_ready) begin
            rcv_q.push_back(dout);
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("xfer_unexpected", 32'd1, 32'd0);
            else chk("xfer_data", 32'(dout), 32'(exp_q.pop_front()));
        end
        prev_rptr = rptr;
        prev_dout = dout;
        prev_hold = dout_valid && !dout_ready;
        @(posedge clk);
        cyc++;
        pop_m = !empty_m && (!valid_m || ready);
        if (pop_m) begin
            data_m  = mem_q.pop_front();
            valid_m = 1'b1;
            rd_cnt++;
        end else if (valid_m && ready) begin
            valid_m = 1'b0;
        end
        empty_m = (mem_q.size() == 0);
        fill_m  = mem_q.size();
        #1;
        chk("model_dout", 32'(dout), 32'(data_m));
        chk("model_valid", 32'(dout_valid), 32'(valid_m));
        chk("model_rempty", 32'(rempty), 32'(empty_m));
        chk("model_rfill", 32'(rfill), 32'(fill_m));
        chk("model_rptr", 32'(rptr), 32'(gray(rd_cnt)));
        chk("model_raddr", 32'(raddr), 32'(rd_cnt % 16));
        if (prev_hold) begin
            chk("hold_dout", 32'(dout), 32'(prev_dout));
            chk("hold_valid", 32'(dout_valid), 32'd1);
        end
        chk("rptr_onebit", 32'($countones(prev_rptr ^ rptr) <= 1), 32'd1);
        chk("rfill_max", 32'(rfill <= 5'd16), 32'd1);
    endtask

    initial begin
        logic       pat [4];
        int         budget;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        model_clear();

        // Single word latency: wptr 0->1, ready low, then one late acceptance.
        vecs[0] = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 5'd0};
        vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 5'd0};
        vecs[2] = '{1, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 5'd1};
        vecs[3] = '{1, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 5'd1};
        vecs[4] = '{1, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 5'd1};
        vecs[5] = '{1, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 5'd1};

        // Reset and hold idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b0);
            check_reset_outputs("idle");
        end

        pend_q.push_back(8'hA5);
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].wtotal - wcnt, vecs[i].ready);
            chk("vec_rempty", 32'(rempty), 32'(vecs[i].e_empty));
            chk("vec_valid", 32'(dout_valid), 32'(vecs[i].e_valid));
            chk("vec_dout", 32'(dout), 32'(vecs[i].e_dout));
            chk("vec_rfill", 32'(rfill), 32'(vecs[i].e_fill));
            chk("vec_rptr", 32'(rptr), 32'(vecs[i].e_rptr));
        end

        // Full memory drained at one word per cycle.
        do_reset();
        for (int i = 0; i < 16; i++) pend_q.push_back(8'(8'h10 + i));
        step(16, 1'b1);
        chk("full_rfill", 32'(rfill), 32'd16);
        for (int i = 0; i < 20; i++) step(0, 1'b1);
        chk("burst_count", 32'(rcv_q.size()), 32'd16);
        for (int i = 0; i < rcv_q.size() && i < 16; i++)
            chk("burst_order", 32'(rcv_q[i]), 32'(8'h10 + i));
        if (xfer_cyc.size() == 16)
            chk("burst_back_to_back", 32'(xfer_cyc[15] - xfer_cyc[0]), 32'd15);
        chk("burst_empty_end", 32'(rempty), 32'd1);

        // Same preload with ready toggling 1,0,0,1.
        do_reset();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 16; i++) pend_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 80; i++) step((i == 0) ? 16 : 0, pat[i % 4]);
        chk("toggle_count", 32'(rcv_q.size()), 32'd16);
        for (int i = 0; i < rcv_q.size() && i < 16; i++)
            chk("toggle_order", 32'(rcv_q[i]), 32'(8'h10 + i));

        // 40 random words, writer up to 3 steps per edge, random ready, pointer wrap.
        do_reset();
        for (int i = 0; i < 40; i++) pend_q.push_back(8'($urandom_range(0, 255)));
        budget = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && budget < 400) begin
            step(3, $urandom_range(0, 3) != 0);
            budget++;
        end
        chk("stream_done", 32'(pend_q.size() + exp_q.size()), 32'd0);
        chk("stream_count", 32'(rcv_q.size()), 32'd40);
        chk("stream_wrapped", 32'(wcnt >= 32), 32'd1);

        // Reset asserted while a word sits in dout with five more unread.
        do_reset();
        for (int i = 0; i < 6; i++) pend_q.push_back(8'(8'h60 + i));
        step(6, 1'b0);
        step(0, 1'b0);
        chk("pre_reset_valid", 32'(dout_valid), 32'd1);
        chk("pre_reset_rfill", 32'(rfill), 32'd5);
        @(negedge clk);
        #2;
        rrst_n   = 1'b0;
        rq2_wptr = '0;
        #1;
        check_reset_outputs("async_reset");
        model_clear();
        @(negedge clk);
        rrst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b1);
            chk("post_reset_rempty", 32'(rempty), 32'd1);
            chk("post_reset_valid", 32'(dout_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
